// File: rtl/alu_cdb_queue.sv
// -----------------------------------------------------------------------------
// alu_cdb_queue
//
// Holds ALU results that are waiting for a common data bus (CDB) slot. The
// results leave strictly in the order they were accepted. The head entry asks
// for the CDB through cdb_valid_o. The CDB arbiter takes it with cdb_grant_i.
// A mispredict squash empties the queue at the next clock edge.
//
// Parameters
//   XLEN   result data width
//   DEPTH  entry count (a power of two, at least 2)
//   PRN_W  physical-register tag width
//   ROB_W  ROB index width
//
// Ports
//   clock_i          rising-edge clock
//   reset_i          asynchronous, active-high reset
//   squash_i         synchronous flush of all entries
//   in_valid_i       ALU result offered this cycle
//   in_result_i      ALU result value
//   in_dest_prn_i    destination physical register
//   in_rob_idx_i     owning ROB entry
//   in_ready_o       queue can accept a result this cycle
//   cdb_valid_o      head entry is requesting the CDB
//   cdb_result_o     head result (zero when empty)
//   cdb_dest_prn_o   head destination tag (zero when empty)
//   cdb_rob_idx_o    head ROB index (zero when empty)
//   cdb_grant_i      CDB arbiter accepts the head entry this cycle
//   count_o          number of occupied entries
// -----------------------------------------------------------------------------
module alu_cdb_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int PRN_W = 6,
    parameter int ROB_W = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             squash_i,
    input  logic             in_valid_i,
    input  logic [XLEN-1:0]  in_result_i,
    input  logic [PRN_W-1:0] in_dest_prn_i,
    input  logic [ROB_W-1:0] in_rob_idx_i,
    output logic             in_ready_o,
    output logic             cdb_valid_o,
    output logic [XLEN-1:0]  cdb_result_o,
    output logic [PRN_W-1:0] cdb_dest_prn_o,
    output logic [ROB_W-1:0] cdb_rob_idx_o,
    input  logic             cdb_grant_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]  result_q   [DEPTH];
    logic [PRN_W-1:0] dest_prn_q [DEPTH];
    logic [ROB_W-1:0] rob_idx_q  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;

    // in_ready_o depends only on registered occupancy. A full queue therefore
    // stays closed for the whole cycle in which its head is granted.
    assign in_ready_o  = (count_q != FULL_CNT);
    assign cdb_valid_o = (count_q != '0);

    // Squash drops any push or grant that arrives in the same cycle.
    assign push = in_valid_i  && in_ready_o  && !squash_i;
    assign pop  = cdb_grant_i && cdb_valid_o && !squash_i;

    // The data outputs are forced to zero when the queue is empty. The storage
    // contents are left stale after a squash.
    assign cdb_result_o   = cdb_valid_o ? result_q[head_q]   : '0;
    assign cdb_dest_prn_o = cdb_valid_o ? dest_prn_q[head_q] : '0;
    assign cdb_rob_idx_o  = cdb_valid_o ? rob_idx_q[head_q]  : '0;

    assign count_o = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (squash_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by natural overflow.
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset. An entry is only read after it is written.
    always_ff @(posedge clock_i) begin
        if (push) begin
            result_q[tail_q]   <= in_result_i;
            dest_prn_q[tail_q] <= in_dest_prn_i;
            rob_idx_q[tail_q]  <= in_rob_idx_i;
        end
    end

endmodule

// File: tb/tb_alu_cdb_queue.sv
module tb_alu_cdb_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int PRN_W = 6;
    localparam int ROB_W = 5;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0]  r;
        logic [PRN_W-1:0] p;
        logic [ROB_W-1:0] b;
    } ent_t;

    logic             clock;
    logic             reset;
    logic             squash;
    logic             in_valid;
    logic [XLEN-1:0]  in_result;
    logic [PRN_W-1:0] in_dest_prn;
    logic [ROB_W-1:0] in_rob_idx;
    logic             in_ready;
    logic             cdb_valid;
    logic [XLEN-1:0]  cdb_result;
    logic [PRN_W-1:0] cdb_dest_prn;
    logic [ROB_W-1:0] cdb_rob_idx;
    logic             cdb_grant;
    logic [CNT_W-1:0] count;

    ent_t sb[$];
    int   checks;
    int   errors;

    alu_cdb_queue #(
        .XLEN (XLEN),
        .DEPTH(DEPTH),
        .PRN_W(PRN_W),
        .ROB_W(ROB_W)
    ) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .squash_i      (squash),
        .in_valid_i    (in_valid),
        .in_result_i   (in_result),
        .in_dest_prn_i (in_dest_prn),
        .in_rob_idx_i  (in_rob_idx),
        .in_ready_o    (in_ready),
        .cdb_valid_o   (cdb_valid),
        .cdb_result_o  (cdb_result),
        .cdb_dest_prn_o(cdb_dest_prn),
        .cdb_rob_idx_o (cdb_rob_idx),
        .cdb_grant_i   (cdb_grant),
        .count_o       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one cycle of stimulus and keeps the scoreboard in step. A granted
    // head is compared against the oldest expected entry. The new input is
    // queued only when the reference occupancy says it is accepted.
    task automatic step(input logic v, input logic [XLEN-1:0] d,
                        input logic [PRN_W-1:0] p, input logic [ROB_W-1:0] b,
                        input logic g, input logic s);
        ent_t exp;
        logic will_push;
        in_valid    = v;
        in_result   = d;
        in_dest_prn = p;
        in_rob_idx  = b;
        cdb_grant   = g;
        squash      = s;
        will_push   = v && (sb.size() < DEPTH) && !s;
        if (g && !s && sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if (cdb_valid !== 1'b1 || cdb_result !== exp.r ||
                cdb_dest_prn !== exp.p || cdb_rob_idx !== exp.b) begin
                errors++;
                $display("FAIL sb_pop: got v=%0b r=%h p=%0d b=%0d, want v=1 r=%h p=%0d b=%0d",
                         cdb_valid, cdb_result, cdb_dest_prn, cdb_rob_idx, exp.r, exp.p, exp.b);
            end
        end
        if (s) begin
            sb.delete();
        end else if (will_push) begin
            sb.push_back('{r: d, p: p, b: b});
        end
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        cdb_grant = 1'b0;
        squash    = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
        checks++;
        if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", cdb_valid); end
        checks++;
        if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++;
        if (cdb_result !== '0 || cdb_dest_prn !== '0 || cdb_rob_idx !== '0) begin
            errors++; $display("FAIL reset_data: got r=%h p=%0d b=%0d want 0", cdb_result, cdb_dest_prn, cdb_rob_idx);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        step(1'b1, 32'h5, 6'd3, 5'd7, 1'b0, 1'b0);
        checks++;
        if (cdb_valid !== 1'b1 || cdb_result !== 32'h5 || cdb_dest_prn !== 6'd3 || cdb_rob_idx !== 5'd7) begin
            errors++;
            $display("FAIL basic_head: got v=%0b r=%h p=%0d b=%0d want v=1 r=5 p=3 b=7",
                     cdb_valid, cdb_result, cdb_dest_prn, cdb_rob_idx);
        end
        checks++;
        if (count !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", count); end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd0 || cdb_valid !== 1'b0) begin
            errors++; $display("FAIL basic_drain: got count=%0d v=%0b want 0 0", count, cdb_valid);
        end
        checks++;
        if (cdb_result !== '0) begin errors++; $display("FAIL basic_empty_zero: got %h want 0", cdb_result); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'hA0 + 32'(i), 6'(i + 1), 5'(i + 10), 1'b0, 1'b0);
        end
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full: got count=%0d rdy=%0b want 4 0", count, in_ready);
        end
        step(1'b1, 32'hEE, 6'd9, 5'd9, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL fill_ignored: got %0d want 4", count); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (count !== 3'd0 || cdb_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL fill_drain: got count=%0d v=%0b rdy=%0b want 0 0 1", count, cdb_valid, in_ready);
        end
    endtask

    task automatic test_full_grant;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'hB0 + 32'(i), 6'(i), 5'(i), 1'b0, 1'b0);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fullg_ready_before: got %0b want 0", in_ready); end
        step(1'b1, 32'hCC, 6'd12, 5'd12, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL fullg_count: got %0d want 3", count); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fullg_ready_after: got %0b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL fullg_drain: got %0d want 0", count); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h10 + 32'(i), 6'(i + 20), 5'(i + 3), (i > 0), 1'b0);
            checks++;
            if (count !== 3'd1 || cdb_result !== 32'h10 + 32'(i)) begin
                errors++; $display("FAIL wrap_%0d: got count=%0d r=%h want 1 %h", i, count, cdb_result, 32'h10 + 32'(i));
            end
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL wrap_drain: got %0d want 0", count); end
    endtask

    task automatic test_squash;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hC0 + 32'(i), 6'(i), 5'(i), 1'b0, 1'b0);
        end
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL squash_pre: got %0d want 3", count); end
        step(1'b1, 32'hDD, 6'd5, 5'd5, 1'b1, 1'b1);
        checks++;
        if (count !== 3'd0 || cdb_valid !== 1'b0) begin
            errors++; $display("FAIL squash_flush: got count=%0d v=%0b want 0 0", count, cdb_valid);
        end
        step(1'b1, 32'h77, 6'd1, 5'd2, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd1 || cdb_result !== 32'h77) begin
            errors++; $display("FAIL squash_after: got count=%0d r=%h want 1 77", count, cdb_result);
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset;
        step(1'b1, 32'hE1, 6'd1, 5'd1, 1'b0, 1'b0);
        step(1'b1, 32'hE2, 6'd2, 5'd2, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL areset_pre: got %0d want 2", count); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_now: got v=%0b count=%0d rdy=%0b want 0 0 1", cdb_valid, count, in_ready);
        end
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1'b1, 32'h55, 6'd4, 5'd4, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd1 || cdb_result !== 32'h55) begin
            errors++; $display("FAIL areset_first_push: got count=%0d r=%h want 1 55", count, cdb_result);
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        squash      = 1'b0;
        in_valid    = 1'b0;
        in_result   = '0;
        in_dest_prn = '0;
        in_rob_idx  = '0;
        cdb_grant   = 1'b0;
        test_reset();
        test_basic();
        test_fill();
        test_full_grant();
        test_back_to_back();
        test_squash();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cdb_queue.md
ALU_CDB_QUEUE -- requirements
Module: alu_cdb_queue

Interface
- REQ-001: Parameter XLEN, default 32; result data width.
- REQ-002: Parameter DEPTH, default 4; entry count; SHALL be a power of two, at least 2.
- REQ-003: Parameter PRN_W, default 6; physical-register tag width.
- REQ-004: Parameter ROB_W, default 5; ROB index width.
- REQ-005: clock  input  1  single clock; all state updates on the rising edge.
- REQ-006: reset  input  1  asynchronous, active-high reset.
- REQ-007: squash  input  1  mispredict flush; discards all entries.
- REQ-008: in_valid  input  1  ALU result offered this cycle.
- REQ-009: in_result  input  XLEN  ALU result value.
- REQ-010: in_dest_prn  input  PRN_W  destination physical register.
- REQ-011: in_rob_idx  input  ROB_W  owning ROB entry.
- REQ-012: in_ready  output  1  queue can accept a result this cycle.
- REQ-013: cdb_valid  output  1  head entry is requesting the CDB.
- REQ-014: cdb_result  output  XLEN  head result.
- REQ-015: cdb_dest_prn  output  PRN_W  head destination tag.
- REQ-016: cdb_rob_idx  output  ROB_W  head ROB index.
- REQ-017: cdb_grant  input  1  CDB arbiter accepts the head entry this cycle.
- REQ-018: count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
- REQ-019: The block SHALL be a FIFO of DEPTH entries, each holding {result, dest_prn, rob_idx}, with head and tail pointers of width $clog2(DEPTH) and an occupancy counter.
- REQ-020: in_ready SHALL be 1 exactly when count < DEPTH, derived from registered state only, with no combinational path from cdb_grant.
- REQ-021: A push SHALL occur when in_valid && in_ready; the entry is written at tail and tail advances by 1.
- REQ-022: in_valid while in_ready is 0 SHALL be ignored, with no state change; the producer holds the result.
- REQ-023: cdb_valid SHALL be 1 exactly when count > 0; cdb_result, cdb_dest_prn and cdb_rob_idx SHALL reflect the head entry, or all zeros when empty.
- REQ-024: A pop SHALL occur when cdb_valid && cdb_grant; head advances by 1.
- REQ-025: cdb_grant while cdb_valid is 0 SHALL be ignored.
- REQ-026: Head and tail SHALL wrap modulo DEPTH.
- REQ-027: On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
- REQ-028: When full, a pop in the same cycle SHALL NOT enable a push; in_ready stays 0 for that cycle.
- REQ-029: Latency: a result pushed in cycle N into an empty queue SHALL appear on the CDB outputs in cycle N+1; there is no same-cycle bypass.
- REQ-030: Ordering SHALL be strictly first in, first out; results leave in acceptance order.
- REQ-031: count SHALL equal pushes minus pops since the last reset or squash, and never exceed DEPTH.
- REQ-032: squash SHALL be synchronous: at the next edge head, tail and count SHALL become 0, taking priority over any push or pop in that cycle.
- REQ-033: A push or grant presented in the same cycle as squash SHALL be dropped.
- REQ-034: Entry storage contents SHALL NOT need clearing on squash; only pointers and count.

Reset
- REQ-035: While reset is high, head, tail and count SHALL be 0 asynchronously, giving cdb_valid=0, CDB data outputs 0 and in_ready=1.
- REQ-036: Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
- REQ-037: The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification
- REQ-038: Basic push: push {0x0000_0005, prn 3, rob 7} into an empty queue -> next cycle cdb_valid=1, cdb_result=0x5, cdb_dest_prn=3, cdb_rob_idx=7, count=1; grant -> count=0, cdb_valid=0.
- REQ-039: Fill: 4 pushes with no grant (DEPTH=4) -> count=4, in_ready=0; a 5th in_valid is ignored; 4 grants return the entries in order, and the 5th value never appears.
- REQ-040: Full plus grant: in a full queue, assert in_valid and cdb_grant together -> count=3 and the offered value is not stored; the next cycle in_ready=1.
- REQ-041: Wrap-around: 10 back-to-back cycles of push 0x10..0x19 with grant every cycle after the first -> CDB sequence 0x10..0x19 in order, count stays 1, pointers wrap without loss.
- REQ-042: Squash: with 3 entries, assert squash with in_valid=1 and cdb_grant=1 -> next cycle count=0, cdb_valid=0, and the offered value is not stored.
- REQ-043: Async reset: assert reset between clock edges while holding 2 entries -> cdb_valid=0 and count=0 before the next edge.
